seq_mult_ctrl: RTL and testbench

//  Ready/valid front-end and sequencer for the 16x16 signed sequential multiplier datapath.

---
 rtl/seq_mult_ctrl.sv | 97 +++++++++
 tb/tb_seq_mult_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: ready/valid sequencer driving a 16x16 signed sequential multiplier datapath
module seq_mult_ctrl #(
  parameter int WIDTH        = 16,
  parameter int DONE_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic [15:0] src_a,
  input  logic [15:0] src_b,
  output logic        dp_load,
  output logic        dp_calc,
  output logic [15:0] dp_a,
  output logic [15:0] dp_b,
  input  logic [31:0] dp_product,
  input  logic        dp_done,
  output logic        dst_valid,
  input  logic        dst_ready,
  output logic [31:0] dst_product,
  output logic        busy,
  output logic        err
);
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_CALC = 3'd2, S_WAIT = 3'd3, S_OUT = 3'd4;
  localparam int CW = 5;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   prod_q, prod_d;
  logic          err_q, err_d;
  logic          calc_last, wait_last;
  assign calc_last = cnt_q == CW'(WIDTH - 1);
  assign wait_last = cnt_q == CW'(DONE_TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (src_valid) begin
        a_d     = src_a;
        b_d     = src_b;
        err_d   = 1'b0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_CALC;
      end
      S_CALC: begin
        cnt_d   = calc_last ? '0 : cnt_q + 1'b1;
        state_d = calc_last ? S_WAIT : S_CALC;
      end
      // cnt is reused as the dp_done watchdog while waiting
      S_WAIT: if (dp_done) begin
        prod_d  = dp_product;
        state_d = S_OUT;
      end else if (wait_last) begin
        err_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end else begin
        cnt_d   = cnt_q + 1'b1;
      end
      S_OUT: state_d = dst_ready ? S_IDLE : S_OUT;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
    end
  end
  assign src_ready   = state_q == S_IDLE;
  assign busy        = state_q != S_IDLE;
  assign dp_load     = state_q == S_LOAD;
  assign dp_calc     = state_q == S_CALC;
  assign dst_valid   = state_q == S_OUT;
  assign dp_a        = a_q;
  assign dp_b        = b_q;
  assign dst_product = prod_q;
  assign err         = err_q;
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb_seq_mult_ctrl: directed and randomised checks of seq_mult_ctrl against a behavioural datapath
module tb_seq_mult_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        src_valid = 1'b0, dst_ready = 1'b0;
  logic [15:0] src_a = '0, src_b = '0;
  logic        src_ready, dp_load, dp_calc, dst_valid, busy, err;
  logic [15:0] dp_a, dp_b;
  logic [31:0] dst_product;
  logic [31:0] dp_product = '0;
  logic        dp_done = 1'b0, kill = 1'b0, sb_on = 1'b0;
  int          total = 0, bad = 0, acc_n = 0, xfer_n = 0, calc_n = 0, dp_n = 0, excl_bad = 0;
  logic [31:0] exp_q[$];

  seq_mult_ctrl dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready), .src_a(src_a), .src_b(src_b),
    .dp_load(dp_load), .dp_calc(dp_calc), .dp_a(dp_a), .dp_b(dp_b), .dp_product(dp_product),
    .dp_done(dp_done), .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_product(dst_product),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // behavioural datapath: result valid after 16 calc steps, held until next load
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_n <= 0; dp_done <= 1'b0; dp_product <= '0; calc_n <= 0;
    end else if (dp_load) begin
      dp_n <= 0; dp_done <= 1'b0; calc_n <= 0;
    end else if (dp_calc) begin
      dp_n <= dp_n + 1;
      calc_n <= calc_n + 1;
      if (dp_n == 15 && !kill) begin
        dp_done <= 1'b1;
        dp_product <= $signed(dp_a) * $signed(dp_b);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // handshake monitor, sampled between the driving negedge and the next rising edge
  always begin
    logic signed [31:0] e;
    @(negedge clk);
    #1;
    if (dp_load && dp_calc) excl_bad++;
    if (!rst && src_valid && src_ready) begin
      acc_n++;
      e = $signed(src_a) * $signed(src_b);
      if (sb_on) exp_q.push_back(e);
    end
    if (!rst && dst_valid && dst_ready) begin
      xfer_n++;
      if (sb_on) begin
        if (exp_q.size() == 0) chk("sb_unexpected", dst_product, 32'hxxxxxxxx);
        else chk("sb_product", dst_product, exp_q.pop_front());
      end
    end
  end

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic rdy,
                       output logic [31:0] p, output int lat, output logic e1);
    src_a = a; src_b = b; src_valid = 1'b1; dst_ready = rdy; lat = -1; p = 'x; e1 = 1'bx;
    for (int i = 0; i < 100 && !src_ready; i++) @(negedge clk);
    if (!src_ready) begin
      src_valid = 1'b0;
      chk("accept_timeout", 32'(src_ready), 32'd1);
    end else begin
      @(negedge clk);
      src_valid = 1'b0;
      e1 = err;
      for (int c = 0; c < 40; c++) begin
        if (dst_valid || err) begin lat = c; p = dst_product; break; end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [31:0] p;
    int lat, x0, a0;
    logic e1;
    logic [15:0] ra, rb;
    #12;
    chk("rst_src_ready", 32'(src_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dst_valid", 32'(dst_valid), 32'd0);
    chk("rst_dp_ctl", {30'd0, dp_load, dp_calc}, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_regs", dst_product | {dp_a, dp_b}, 32'd0);
    @(negedge clk); rst = 1'b0; @(negedge clk);

    do_op(16'd3, 16'd5, 1'b1, p, lat, e1);
    chk("3x5", p, 32'h0000000F);
    chk("latency", 32'(lat), 32'd18);
    chk("calc_cycles", 32'(calc_n), 32'd16);
    @(negedge clk);
    chk("dst_valid_drop", 32'(dst_valid), 32'd0);

    do_op(16'hFFFF, 16'hFFFF, 1'b1, p, lat, e1); chk("m1xm1", p, 32'h00000001);
    do_op(16'h8000, 16'h8000, 1'b1, p, lat, e1); chk("min_x_min", p, 32'h40000000);
    do_op(16'h7FFF, 16'h8000, 1'b1, p, lat, e1); chk("max_x_min", p, 32'hC0008000);
    do_op(16'h0000, 16'hFFFF, 1'b1, p, lat, e1); chk("0xm1", p, 32'h00000000);
    @(negedge clk);

    do_op(16'd100, 16'hFFF9, 1'b0, p, lat, e1);
    chk("bp_latency", 32'(lat), 32'd18);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(dst_valid), 32'd1);
      chk("bp_product", dst_product, 32'hFFFFFD44);
      chk("bp_src_ready", 32'(src_ready), 32'd0);
      @(negedge clk);
    end
    x0 = xfer_n;
    dst_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("bp_single_xfer", 32'(xfer_n - x0), 32'd1);
    chk("bp_valid_low", 32'(dst_valid), 32'd0);

    a0 = acc_n;
    src_a = 16'd2; src_b = 16'd3; src_valid = 1'b1;
    for (int i = 0; i < 20 && !src_ready; i++) @(negedge clk);
    @(negedge clk);
    src_a = 16'd4; src_b = 16'd5;
    for (int i = 0; i < 20 && !dp_calc; i++) @(negedge clk);
    chk("ovl_src_ready", 32'(src_ready), 32'd0);
    chk("ovl_dp_a_stable", {dp_a, dp_b}, {16'd2, 16'd3});
    for (int i = 0; i < 40 && !dst_valid; i++) @(negedge clk);
    chk("ovl_first", dst_product, 32'd6);
    chk("ovl_calc1", 32'(calc_n), 32'd16);
    @(negedge clk);
    for (int i = 0; i < 5 && !src_ready; i++) @(negedge clk);
    @(negedge clk);
    src_valid = 1'b0;
    for (int i = 0; i < 40 && !dst_valid; i++) @(negedge clk);
    chk("ovl_second", dst_product, 32'd20);
    chk("ovl_calc2", 32'(calc_n), 32'd16);
    chk("ovl_accepts", 32'(acc_n - a0), 32'd2);
    @(negedge clk);

    src_a = 16'd7; src_b = 16'd7; src_valid = 1'b1;
    for (int i = 0; i < 20 && !src_ready; i++) @(negedge clk);
    @(negedge clk);
    src_valid = 1'b0;
    for (int i = 0; i < 40 && calc_n != 8; i++) @(negedge clk);
    chk("mid_calc", {31'd0, dp_calc}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(src_ready), 32'd1);
    chk("rst_mid_outs", {26'd0, busy, dp_load, dp_calc, dst_valid, err, 1'b0} | dst_product | {dp_a, dp_b}, 32'd0);
    @(negedge clk); rst = 1'b0; @(negedge clk);
    do_op(16'd9, 16'd9, 1'b1, p, lat, e1);
    chk("9x9_after_rst", p, 32'h00000051);
    @(negedge clk);

    kill = 1'b1;
    x0 = xfer_n;
    do_op(16'd1, 16'd1, 1'b1, p, lat, e1);
    chk("to_err", 32'(err), 32'd1);
    chk("to_cycles", 32'(lat), 32'd21);
    chk("to_idle", {30'd0, busy, src_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("to_no_xfer", 32'(xfer_n - x0), 32'd0);
    chk("to_err_sticky", 32'(err), 32'd1);
    kill = 1'b0;
    do_op(16'd2, 16'd2, 1'b1, p, lat, e1);
    chk("to_err_clear", 32'(e1), 32'd0);
    chk("to_recover", p, 32'd4);
    @(negedge clk);

    exp_q.delete();
    sb_on = 1'b1;
    a0 = acc_n; x0 = xfer_n;
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) begin
        src_valid = 1'b0; dst_ready = ($urandom_range(0, 3) != 0); @(negedge clk);
      end
      ra = 16'($urandom); rb = 16'($urandom);
      src_a = ra; src_b = rb; src_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
        logic took;
        dst_ready = ($urandom_range(0, 3) != 0);
        took = src_ready;
        @(negedge clk);
        if (took) break;
      end
      src_valid = 1'b0;
    end
    dst_ready = 1'b1;
    for (int i = 0; i < 60 && xfer_n - x0 < 300; i++) @(negedge clk);
    chk("rnd_accepts", 32'(acc_n - a0), 32'd300);
    chk("rnd_results", 32'(xfer_n - x0), 32'd300);
    chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("load_calc_excl", 32'(excl_bad), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
